// File: rtl/debouncer_bank.sv
// Multi-channel push-button debouncer: per-channel synchroniser and stable-time
// filter, press/release pulses, and long-press detection with optional auto-repeat.
module debouncer_bank #(
  parameter int unsigned N             = 4,
  parameter int unsigned THRESH        = 16,
  parameter bit          INVERT        = 1'b1,
  parameter int unsigned HOLD_CYCLES   = 1000000,
  parameter int unsigned REPEAT_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] pos,
  output logic [N-1:0] neg,
  output logic [N-1:0] hold,
  output logic [N-1:0] rpt,
  output logic [N-1:0] held,
  output logic         any_evt
);

  localparam int unsigned CW   = $clog2(THRESH);
  localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW   = $clog2(HMAX);
  localparam logic [CW-1:0] CNT_LAST  = CW'(THRESH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESSED, HELD} hstate_t;

  logic [N-1:0]  sync_a, sync_b;
  logic [N-1:0]  idle, term, rise, fall;
  logic [CW-1:0] cnt [N];

  hstate_t       state    [N];
  hstate_t       state_nx [N];
  logic [HW-1:0] hcnt     [N];
  logic [HW-1:0] hcnt_nx  [N];
  logic [N-1:0]  hold_nx, rpt_nx;

  // term marks the edge on which q toggles; rise/fall are that toggle seen in advance
  always_comb begin
    idle = '0;
    term = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idle[i] = (q[i] == sync_b[i]);
      term[i] = !idle[i] && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = term & ~q;
  assign fall = term & q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      q      <= '0;
      pos    <= '0;
      neg    <= '0;
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync_a <= INVERT ? ~d : d;
      sync_b <= sync_a;
      q      <= q ^ term;
      pos    <= rise;
      neg    <= fall;
      for (int unsigned i = 0; i < N; i++) begin
        if (idle[i] || term[i]) cnt[i] <= '0;
        else                    cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      rpt  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        state[i] <= RELEASED;
        hcnt[i]  <= '0;
      end
    end else begin
      hold <= hold_nx;
      rpt  <= rpt_nx;
      for (int unsigned i = 0; i < N; i++) begin
        state[i] <= state_nx[i];
        hcnt[i]  <= hcnt_nx[i];
      end
    end
  end

  // A falling q is checked ahead of the state case so neg overrides hold/rpt terminals
  always_comb begin
    hold_nx = '0;
    rpt_nx  = '0;
    held    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      state_nx[i] = state[i];
      hcnt_nx[i]  = hcnt[i];
      held[i]     = (state[i] == HELD);
      if (fall[i]) begin
        state_nx[i] = RELEASED;
        hcnt_nx[i]  = '0;
      end else begin
        case (state[i])
          RELEASED: begin
            if (rise[i]) begin
              state_nx[i] = PRESSED;
              hcnt_nx[i]  = '0;
            end
          end
          PRESSED: begin
            if (hcnt[i] == HOLD_LAST) begin
              state_nx[i] = HELD;
              hcnt_nx[i]  = '0;
              hold_nx[i]  = 1'b1;
            end else begin
              hcnt_nx[i] = hcnt[i] + 1'b1;
            end
          end
          HELD: begin
            if (REPEAT_CYCLES == 0) begin
              hcnt_nx[i] = '0;
            end else if (hcnt[i] == RPT_LAST) begin
              hcnt_nx[i] = '0;
              rpt_nx[i]  = 1'b1;
            end else begin
              hcnt_nx[i] = hcnt[i] + 1'b1;
            end
          end
          default: begin
            state_nx[i] = RELEASED;
            hcnt_nx[i]  = '0;
          end
        endcase
      end
    end
  end

  assign any_evt = |(pos | neg | hold | rpt);

endmodule

// File: tb/tb_debouncer_bank.sv
// Scoreboard bench for debouncer_bank: each scenario queues (input, expected
// output) pairs per clock edge, then replays them and compares after each edge.
module tb_debouncer_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] d = 2'b11;
  logic [1:0] q, pos, neg, hold, rpt, held;
  logic       any_evt;
  logic [12:0] obs;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  d;
    logic [12:0] e;
  } ent_t;

  ent_t sb [$];

  debouncer_bank #(
    .N            (2),
    .THRESH       (4),
    .INVERT       (1'b1),
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .q      (q),
    .pos    (pos),
    .neg    (neg),
    .hold   (hold),
    .rpt    (rpt),
    .held   (held),
    .any_evt(any_evt)
  );

  always #5 clk = ~clk;

  assign obs = {q, pos, neg, hold, rpt, held, any_evt};

  function automatic logic [12:0] mk(input logic [1:0] q_, input logic [1:0] pos_,
                                     input logic [1:0] neg_, input logic [1:0] hold_,
                                     input logic [1:0] rpt_, input logic [1:0] held_);
    return {q_, pos_, neg_, hold_, rpt_, held_, |{pos_, neg_, hold_, rpt_}};
  endfunction

  function automatic logic [1:0] c0(input bit b);
    return {1'b0, b};
  endfunction

  task automatic test_reset();
    ent_t e;
    int   k;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 13'd0) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b", obs, 13'd0);
    end
    for (int i = 0; i < 3; i++) sb.push_back('{d: 2'b11, e: 13'd0});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL reset_hold k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) sb.push_back('{d: 2'b11, e: 13'd0});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL reset_idle k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
  endtask

  task automatic test_press_hold();
    ent_t e;
    int   k;
    for (int i = 1; i <= 33; i++)
      sb.push_back('{d: 2'b10, e: mk(c0(i >= 6), c0(i == 6), 2'b00, c0(i == 16),
                                    c0(i == 21 || i == 26 || i == 31), c0(i >= 16))});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL press_hold k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
  endtask

  task automatic test_release();
    ent_t e;
    int   k;
    for (int i = 1; i <= 15; i++)
      sb.push_back('{d: 2'b11, e: mk(c0(i < 6), 2'b00, c0(i == 6), 2'b00,
                                    c0(i == 3), c0(i < 6))});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL release k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
  endtask

  task automatic test_release_on_rpt();
    ent_t e;
    int   k;
    for (int i = 1; i <= 20; i++)
      sb.push_back('{d: 2'b10, e: mk(c0(i >= 6), c0(i == 6), 2'b00, c0(i == 16),
                                    2'b00, c0(i >= 16))});
    for (int i = 1; i <= 10; i++)
      sb.push_back('{d: 2'b11, e: mk(c0(i < 6), 2'b00, c0(i == 6), 2'b00,
                                    c0(i == 1), c0(i < 6))});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL release_on_rpt k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
  endtask

  task automatic test_release_on_hold();
    ent_t e;
    int   k;
    for (int i = 1; i <= 10; i++)
      sb.push_back('{d: 2'b10, e: mk(c0(i >= 6), c0(i == 6), 2'b00, 2'b00, 2'b00, 2'b00)});
    for (int i = 1; i <= 10; i++)
      sb.push_back('{d: 2'b11, e: mk(c0(i < 6), 2'b00, c0(i == 6), 2'b00, 2'b00, 2'b00)});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL release_on_hold k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
  endtask

  task automatic test_glitch();
    ent_t e;
    int   k;
    for (int i = 1; i <= 40; i++)
      sb.push_back('{d: (((i - 1) / 2) % 2 == 0) ? 2'b10 : 2'b11, e: 13'd0});
    for (int i = 1; i <= 18; i++)
      sb.push_back('{d: 2'b10, e: mk(c0(i >= 6), c0(i == 6), 2'b00, c0(i == 16),
                                    2'b00, c0(i >= 16))});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
  endtask

  task automatic test_async_reset();
    ent_t e;
    int   k;
    #3;
    d     = 2'b00;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 13'd0) begin
      bad++;
      $display("FAIL async_drop got=%b want=%b", obs, 13'd0);
    end
    for (int i = 0; i < 3; i++) sb.push_back('{d: 2'b00, e: 13'd0});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL async_in_reset k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 10; i++)
      sb.push_back('{d: 2'b00, e: mk({2{i >= 6}}, {2{i == 6}}, 2'b00, 2'b00, 2'b00, 2'b00)});
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      d = e.d;
      @(posedge clk); #1; k++;
      total++;
      if (obs !== e.e) begin
        bad++;
        $display("FAIL async_after k=%0d got=%b want=%b", k, obs, e.e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_hold();
    test_release();
    test_release_on_rpt();
    test_release_on_hold();
    test_glitch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
